// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, exception codes and register field positions.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR fields
  localparam int IM_MSB  = 15;
  localparam int IM_LSB  = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  // Cause fields
  localparam int BD_BIT  = 31;
  localparam int IP_MSB  = 15;
  localparam int IP_LSB  = 10;
  localparam int EXC_MSB = 6;
  localparam int EXC_LSB = 2;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] r;
    r = 32'h0;
    r[IM_MSB:IM_LSB] = im;
    r[EXL_BIT] = exl;
    r[IE_BIT] = ie;
    return r;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] r;
    r = 32'h0;
    r[BD_BIT] = bd;
    r[IP_MSB:IP_LSB] = ip;
    r[EXC_MSB:EXC_LSB] = exc;
    return r;
  endfunction

endpackage

// File: rtl/cp0_int_arb.sv
// cp0_int_arb: decides whether the pipeline diverts this cycle and which
// exception code gets captured. Interrupts take priority over internal
// exceptions; nothing is accepted while EXL is set.
module cp0_int_arb
  import cp0_pkg::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code,
  output logic       int_pending,
  output logic       exc_pending,
  output logic       int_req,
  output logic [4:0] sel_code
);

  // Live HWInt is used here (not the registered IP) so the request is same-cycle.
  always_comb begin
    int_pending = (|(hw_int & im)) & ie & ~exl;
    exc_pending = (exc_code != EXC_INT) & ~exl;
    int_req     = int_pending | exc_pending;
    sel_code    = int_pending ? EXC_INT : exc_code;
  end

endmodule

// File: rtl/cp0.sv
// cp0: coprocessor-0 register file (SR, Cause, EPC, PRId) and exception entry/return.
// Optional feature macro: CP0_BD_EN -- records branch-delay-slot victims in
// Cause.BD and backs EPC up to the branch (PC-4). Without it BD is ignored.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h4D495053
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic [4:0]  cause_exc;
  logic        cause_bd;
  logic [31:2] epc;

  logic        int_pending;
  logic        exc_pending;
  logic [4:0]  sel_code;
  logic [31:2] victim_epc;
  logic [1:0]  unused_pc_lo;

  assign unused_pc_lo = PC[1:0];

  cp0_int_arb u_arb (
    .hw_int      (HWInt),
    .im          (im),
    .ie          (ie),
    .exl         (exl),
    .exc_code    (ExcCode),
    .int_pending (int_pending),
    .exc_pending (exc_pending),
    .int_req     (IntReq),
    .sel_code    (sel_code)
  );

`ifdef CP0_BD_EN
  // A delay-slot victim resumes at its branch, one word earlier.
  always_comb begin
    victim_epc = BD ? (PC[31:2] - 30'd1) : PC[31:2];
  end

  // Cause.BD is captured on every handler entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cause_bd <= 1'b0;
    end else if (IntReq) begin
      cause_bd <= BD;
    end
  end
`else
  logic unused_bd;
  assign unused_bd = BD;

  // Without delay-slot tracking the victim always resumes at its own PC.
  always_comb begin
    victim_epc = PC[31:2];
  end

  assign cause_bd = 1'b0;
`endif

  // Register update: entry beats mtc0 (victim re-executes), eret beats mtc0 on EXL.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      im        <= 6'h0;
      exl       <= 1'b0;
      ie        <= 1'b0;
      ip        <= 6'h0;
      cause_exc <= 5'h0;
      epc       <= 30'h0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        exl       <= 1'b1;
        cause_exc <= sel_code;
        epc       <= victim_epc;
      end else begin
        if (We && (A2 == REG_SR)) begin
          im  <= DIn[IM_MSB:IM_LSB];
          exl <= DIn[EXL_BIT];
          ie  <= DIn[IE_BIT];
        end
        if (We && (A2 == REG_EPC)) begin
          epc <= DIn[31:2];
        end
        if (EXLClr) begin
          exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read port: plain read of current state, no bypass of a same-cycle mtc0.
  always_comb begin
    DOut = 32'h0;
    case (A1)
      REG_SR:    DOut = pack_sr(im, exl, ie);
      REG_CAUSE: DOut = pack_cause(cause_bd, ip, cause_exc);
      REG_EPC:   DOut = {epc, 2'b00};
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'h0;
    endcase
  end

  assign EPCOut = {epc, 2'b00};

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed self-checking bench for cp0.
module tb_cp0;

  logic        CLK;
  logic        RST;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  int passed = 0;
  int total  = 0;

  cp0 dut (
    .CLK     (CLK),
    .RST     (RST),
    .A1      (A1),
    .A2      (A2),
    .DIn     (DIn),
    .We      (We),
    .PC      (PC),
    .BD      (BD),
    .ExcCode (ExcCode),
    .HWInt   (HWInt),
    .EXLClr  (EXLClr),
    .IntReq  (IntReq),
    .EPCOut  (EPCOut),
    .DOut    (DOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    #1;
    chk(tag, DOut, exp);
  endtask

  initial begin
    RST = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; We = 1'b0; PC = 32'h0;
    BD = 1'b0; ExcCode = 5'd0; HWInt = 6'h0; EXLClr = 1'b0;
    #2;
    chk("reset_intreq", {31'h0, IntReq}, 32'h0);
    chk("reset_epcout", EPCOut, 32'h0);
    rd("reset_sr", 5'd12, 32'h0);
    rd("reset_cause", 5'd13, 32'h0);
    rd("prid", 5'd15, 32'h4D495053);
    tick;
    RST = 1'b0;
    tick;

    // Timer interrupt entry
    We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick;
    We = 1'b0;
    rd("sr_write", 5'd12, 32'h0000_0401);
    rd("other_reg", 5'd3, 32'h0);
    PC = 32'h0000_3010; HWInt = 6'b000001;
    #1;
    chk("timer_intreq", {31'h0, IntReq}, 32'h1);
    tick;
    rd("timer_sr_exl", 5'd12, 32'h0000_0403);
    rd("timer_cause", 5'd13, 32'h0000_0400);
    chk("timer_epc", EPCOut, 32'h0000_3010);
    chk("exl_blocks", {31'h0, IntReq}, 32'h0);

    // eret with concurrent mtc0 SR setting EXL: EXLClr wins, interrupt re-arms
    EXLClr = 1'b1; We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403;
    tick;
    EXLClr = 1'b0; We = 1'b0;
    rd("eret_sr", 5'd12, 32'h0000_0401);
    chk("eret_rearm", {31'h0, IntReq}, 32'h1);
    HWInt = 6'h0;
    #1;
    chk("quiet_intreq", {31'h0, IntReq}, 32'h0);

    // Masked interrupt on HWInt[1]
    HWInt = 6'b000010;
    #1;
    chk("masked_intreq", {31'h0, IntReq}, 32'h0);
    tick;
    rd("masked_ip", 5'd13, 32'h0000_0800);

    // mtc0 to Cause ignored; EPC write not bypassed, visible next cycle
    HWInt = 6'h0;
    We = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    tick;
    A2 = 5'd14; DIn = 32'h1234_5677;
    rd("cause_ro", 5'd13, 32'h0);
    rd("epc_no_bypass", 5'd14, 32'h0000_3010);
    tick;
    We = 1'b0;
    rd("epc_write", 5'd14, 32'h1234_5674);
    chk("epcout_write", EPCOut, 32'h1234_5674);

    // Interrupt beats a concurrent internal exception
    HWInt = 6'b000001; ExcCode = 5'd12; PC = 32'h0000_3040;
    #1;
    chk("prio_intreq", {31'h0, IntReq}, 32'h1);
    tick;
    rd("prio_cause", 5'd13, 32'h0000_0400);
    chk("prio_epc", EPCOut, 32'h0000_3040);
    ExcCode = 5'd0; HWInt = 6'h0; EXLClr = 1'b1;
    tick;
    EXLClr = 1'b0;

    // Internal exception; concurrent mtc0 to EPC dropped
    ExcCode = 5'd12; PC = 32'h0000_3050;
    We = 1'b1; A2 = 5'd14; DIn = 32'hABCD_0000;
    #1;
    chk("exc_intreq", {31'h0, IntReq}, 32'h1);
    tick;
    We = 1'b0;
    chk("exc_epc_mtc0_drop", EPCOut, 32'h0000_3050);
    rd("exc_cause", 5'd13, 32'h0000_0030);
    chk("exc_no_nest", {31'h0, IntReq}, 32'h0);
    ExcCode = 5'd0; EXLClr = 1'b1;
    tick;
    EXLClr = 1'b0;

    // Delay-slot victim
    ExcCode = 5'd10; BD = 1'b1; PC = 32'h0000_3020;
    tick;
    ExcCode = 5'd0; BD = 1'b0;
`ifdef CP0_BD_EN
    chk("bd_epc", EPCOut, 32'h0000_301C);
    rd("bd_cause", 5'd13, 32'h8000_0028);
`else
    chk("bd_epc", EPCOut, 32'h0000_3020);
    rd("bd_cause", 5'd13, 32'h0000_0028);
`endif

    // Asynchronous reset mid-handler
    @(negedge CLK);
    RST = 1'b1;
    #1;
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    chk("rst_epcout", EPCOut, 32'h0);
    chk("rst_intreq", {31'h0, IntReq}, 32'h0);
    tick;
    RST = 1'b0;
    tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
